// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: FIFO-buffered single-issue controller with RAW scoreboard and illegal-func drop.
// Define HAZARD_CHECK_EN to let the scoreboard gate issue; otherwise it is only observed.
module pipe_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int WB_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_rs1,
  input  logic [3:0]                 in_rs2,
  input  logic [3:0]                 in_rd,
  input  logic [3:0]                 in_func,
  input  logic [7:0]                 in_addr,
  input  logic                       hold,
  output logic                       out_valid,
  output logic [3:0]                 out_rs1,
  output logic [3:0]                 out_rs2,
  output logic [3:0]                 out_rd,
  output logic [3:0]                 out_func,
  output logic [7:0]                 out_addr,
  output logic [15:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_illegal,
  output logic [15:0]                stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [23:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [WB_LAT-1:0] sv;
  logic [3:0] srd [WB_LAT];
  logic [3:0] h_rs1, h_rs2, h_rd, h_func;
  logic [7:0] h_addr;
  logic empty, push, illegal, hazard, issue, pop, stall;
  assign {h_rs1, h_rs2, h_rd, h_func, h_addr} = mem[rp];
  assign empty = fifo_count == '0;
  assign in_ready = fifo_count < FULL;
  assign push = in_valid && in_ready;
  assign illegal = !empty && h_func[3:2] == 2'b11;
`ifdef HAZARD_CHECK_EN
  assign hazard = busy_mask[h_rs1] || busy_mask[h_rs2];
`else
  assign hazard = 1'b0;
`endif
  assign issue = !empty && !illegal && !hazard && !hold;
  assign pop = issue || illegal;
  assign stall = !empty && !illegal && !hold && hazard;
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < WB_LAT; i++)
      if (sv[i]) busy_mask[srd[i]] = 1'b1;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      sv <= '0;
      for (int i = 0; i < WB_LAT; i++) srd[i] <= '0;
      out_valid <= 1'b0;
      {out_rs1, out_rs2, out_rd, out_func, out_addr} <= '0;
      err_illegal <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      sv[0] <= issue;
      srd[0] <= h_rd;
      for (int i = 1; i < WB_LAT; i++) begin
        sv[i] <= sv[i-1];
        srd[i] <= srd[i-1];
      end
      out_valid <= issue;
      if (issue) {out_rs1, out_rs2, out_rd, out_func, out_addr} <= {h_rs1, h_rs2, h_rd, h_func, h_addr};
      err_illegal <= illegal;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl: directed bench with an issue-order scoreboard queue for pipe_issue_ctrl.
module tb_pipe_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, hold = 1'b0;
  logic in_ready, out_valid, err_illegal;
  logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
  logic [7:0] in_addr = '0;
  logic [3:0] out_rs1, out_rs2, out_rd, out_func;
  logic [7:0] out_addr;
  logic [15:0] busy_mask, stall_cnt;
  logic [2:0] fifo_count;
  logic [23:0] exp_q[$];
  int tests = 0, fails = 0, cyc = 0, ca = 0, cb = 0;
  bit issued = 0, done = 0;

  pipe_issue_ctrl #(.DEPTH(4), .WB_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .hold(hold), .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_func(out_func), .out_addr(out_addr), .busy_mask(busy_mask),
    .fifo_count(fifo_count), .err_illegal(err_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    #1;
    cyc++;
    issued = out_valid;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_issue", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("issue_fields", {8'h0, out_rs1, out_rs2, out_rd, out_func, out_addr}, {8'h0, e});
      end
    end
  endtask

  task automatic drive(input logic [3:0] rs1, rs2, rd, func, input logic [7:0] addr, input bit acc);
    {in_rs1, in_rs2, in_rd, in_func, in_addr} = {rs1, rs2, rd, func, addr};
    in_valid = 1'b1;
    if (acc) exp_q.push_back({rs1, rs2, rd, func, addr});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy_mask), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 1'b0;
    // single instruction latency and scoreboard lifetime
    drive(1, 2, 3, 0, 8'h10, 1);
    tick();
    in_valid = 1'b0;
    chk("lat_no_early", 32'(out_valid), 0);
    chk("lat_count1", 32'(fifo_count), 1);
    tick();
    chk("lat_issue", 32'(out_valid), 1);
    chk("lat_busy0", 32'(busy_mask), 32'h0008);
    tick();
    chk("lat_single", 32'(out_valid), 0);
    chk("lat_busy1", 32'(busy_mask), 32'h0008);
    tick();
    chk("lat_busy2", 32'(busy_mask), 32'h0008);
    tick();
    chk("lat_busy_clr", 32'(busy_mask), 0);
    // dependent pair
    drive(0, 0, 5, 1, 8'h20, 1);
    tick();
    drive(5, 0, 6, 2, 8'h21, 1);
    tick();
    in_valid = 1'b0;
    chk("dep_a_issue", 32'(issued), 1);
    ca = cyc;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (issued) begin cb = cyc; done = 1; end
    end
`ifdef HAZARD_CHECK_EN
    chk("dep_gap", 32'(cb - ca), 4);
    chk("dep_stall", 32'(stall_cnt), 3);
`else
    chk("dep_gap", 32'(cb - ca), 1);
    chk("dep_stall", 32'(stall_cnt), 0);
`endif
    repeat (4) tick();
    // hold with FIFO filling past capacity
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'(i), 4'(i), 4'(8 + i), 4'(i), 8'(8'h30 + i), i < 4);
      tick();
      chk("hold_no_issue", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    chk("hold_full", 32'(fifo_count), 4);
    chk("hold_not_ready", 32'(in_ready), 0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_b2b", 32'(out_valid), 1);
    end
    tick();
    chk("hold_drained", 32'(fifo_count), 0);
    repeat (4) tick();
    // illegal func dropped between two legal entries
    hold = 1'b1;
    drive(4, 4, 12, 4, 8'h50, 1);
    tick();
    drive(0, 0, 1, 4'hD, 8'h51, 0);
    tick();
    drive(5, 5, 13, 5, 8'h52, 1);
    tick();
    in_valid = 1'b0;
    hold = 1'b0;
    tick();
    chk("ill_pre_issue", 32'(out_valid), 1);
    chk("ill_count2", 32'(fifo_count), 2);
    tick();
    chk("ill_err", 32'(err_illegal), 1);
    chk("ill_no_issue", 32'(out_valid), 0);
    chk("ill_count1", 32'(fifo_count), 1);
    tick();
    chk("ill_err_once", 32'(err_illegal), 0);
    chk("ill_next_issue", 32'(out_valid), 1);
    chk("ill_count0", 32'(fifo_count), 0);
    repeat (4) tick();
    // continuous push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 4'(1 + i % 15), 4'(i % 12), 8'(i), 1);
      tick();
      if (i > 0) begin
        chk("stream_count", 32'(fifo_count), 1);
        chk("stream_issue", 32'(out_valid), 1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_last", 32'(out_valid), 1);
    chk("stream_empty", 32'(fifo_count), 0);
    chk("stream_all_out", 32'(exp_q.size()), 0);
    repeat (4) tick();
    // reset with queued and in-flight work
    hold = 1'b1;
    drive(0, 0, 7, 1, 8'h60, 1);
    tick();
    drive(0, 0, 9, 1, 8'h61, 1);
    tick();
    hold = 1'b0;
    drive(0, 0, 10, 1, 8'h62, 1);
    tick();
    drive(0, 0, 10, 1, 8'h63, 1);
    tick();
    hold = 1'b1;
    drive(0, 0, 10, 1, 8'h64, 1);
    tick();
    in_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 3);
    chk("mid_busy", 32'(busy_mask), 32'h0280);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_fields", {8'h0, out_rs1, out_rs2, out_rd, out_func, out_addr}, 0);
    chk("arst_busy", 32'(busy_mask), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_err", 32'(err_illegal), 0);
    chk("arst_stall", 32'(stall_cnt), 0);
    exp_q.delete();
    hold = 1'b0;
    #1 rst = 1'b0;
    drive(7, 9, 2, 0, 8'h70, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_issue", 32'(out_valid), 1);
    chk("post_rst_stall", 32'(stall_cnt), 0);
    chk("post_rst_q", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue controller for the 4-stage register-bank/memory pipeline. Buffers incoming instructions (rs1, rs2, rd, func, addr) in a small FIFO and issues at most one per clock to the pipeline's stage-1 inputs. Holds back any instruction whose source register is still being written by an in-flight instruction (RAW scoreboard), and drops illegal function codes. Sits between the instruction source and the pipeline input stage.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2
- WB_LAT, 3, cycles from issue until the issued rd is written back; ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept
- in_rs1, in_rs2, in_rd, in_func  in  4 each  instruction fields
- in_addr  in  8  memory address field
- hold  in  1  downstream freeze; suppresses issue
- out_valid  out  1  issued instruction valid this cycle
- out_rs1, out_rs2, out_rd, out_func  out  4 each  issued fields
- out_addr  out  8  issued address
- busy_mask  out  16  bit r set while register r has a pending write
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- err_illegal  out  1  one-cycle pulse when an illegal func is dropped
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Push: in_valid && in_ready at an edge writes the entry at the tail. in_ready = (fifo_count < DEPTH); no pass-through when full, even with a same-cycle pop.
- Head evaluation is combinational on the FIFO head each cycle:
  - Illegal: func 4'b1100–4'b1111. The head pops with no issue, and err_illegal is asserted for the following cycle. The scoreboard is untouched. Illegal drops ignore hold and hazards.
  - Hazard: busy_mask[rs1] or busy_mask[rs2]. Both sources are always checked, whatever func is.
  - Issue: non-empty, legal, no hazard, hold=0. The head pops. out_* register the head fields and out_valid<=1.
  - Otherwise out_valid<=0 and out_* keep their last values.
- Scoreboard: shift register of WB_LAT slots, each {v, rd}.
  - Every edge: slot0 <= {issue, head rd}; slot i <= slot i-1. The last slot shifts out.
  - busy_mask = OR of one-hot(rd) over valid slots.
  - Slots shift even when hold=1, so in-flight instructions drain.
- stall_cnt: +1 on each edge where the head is legal, hold=0 and a hazard blocks it. Saturates at 16'hFFFF.
- Push and pop in the same cycle: fifo_count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values: in_ready=1, out_valid=0, out_*=0, busy_mask=0, fifo_count=0, err_illegal=0, stall_cnt=0. FIFO and scoreboard are cleared.
- Reset asserted mid-operation discards all queued and in-flight state immediately.
- Latency, empty FIFO and no hazard: instruction pushed at edge k, out_valid high after edge k+1.
- Throughput: 1 issue per cycle for independent instructions.
- Dependent pair (B reads A's rd) with WB_LAT=3:
  - A issues at edge n; rd is busy after edges n..n+2 and clears after edge n+3.
  - B issues at edge n+4 at the earliest, giving 3 stall cycles.
- hold=1 forces out_valid=0 at the next edge. The FIFO still accepts pushes until full.
- err_illegal and out_valid are never both high in the same cycle.

## Configuration
- HAZARD_CHECK_EN defined: scoreboard gates issue as described.
- HAZARD_CHECK_EN undefined:
  - Hazard is forced to 0 and the head issues whenever legal and hold=0.
  - busy_mask is still computed, for observability.
  - stall_cnt stays 0.

## Test plan
- Reset, then push {rs1=1, rs2=2, rd=3, func=0, addr=8'h10} at edge 1 -> out_valid=1 after edge 2 with identical fields; busy_mask=16'h0008 for 3 cycles, then 0.
- Push A {rd=5} then B {rs1=5} on consecutive edges, HAZARD_CHECK_EN defined -> B issues 4 edges after A, stall_cnt=3. Undefined -> B issues the edge after A, stall_cnt=0.
- hold=1 with 5 pushes offered, DEPTH=4 -> fifo_count=4, in_ready=0, out_valid=0. Release hold -> 4 back-to-back issues in order (independent registers).
- Head with func=4'b1101 -> no out_valid, err_illegal pulses once, fifo_count decrements, next entry issues the following edge.
- Push/pop every cycle for 20 cycles with DEPTH=4 -> no loss or reorder across pointer wrap; fifo_count steady.
- Assert rst while 3 entries are queued and 2 are in flight -> all outputs at reset values immediately; the first post-reset push issues with no stall.
